// File: rtl/uart_cmd_responder_if.sv
// uart_cmd_responder_if: UART byte, matcher and hash signals seen by the command responder.
interface uart_cmd_responder_if #(
    parameter int MATCH_BYTES = 19
);
    logic                     rx_data_ready;
    logic [7:0]               rx_data;
    logic                     tx_busy;
    logic                     tx_start;
    logic [7:0]               tx_data;
    logic [127:0]             target_hash;
    logic                     hash_valid;
    logic                     text_valid;
    logic [7:0]               text_byte;
    logic                     text_last;
    logic                     proc_done;
    logic                     match;
    logic [15:0]              match_pos;
    logic [8*MATCH_BYTES-1:0] match_str;
    logic                     busy;

    modport slave (
        input  rx_data_ready, rx_data, tx_busy, proc_done, match, match_pos, match_str,
        output tx_start, tx_data, target_hash, hash_valid, text_valid, text_byte, text_last, busy
    );

    modport master (
        output rx_data_ready, rx_data, tx_busy, proc_done, match, match_pos, match_str,
        input  tx_start, tx_data, target_hash, hash_valid, text_valid, text_byte, text_last, busy
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: decodes host UART opcodes, loads the target hash, streams text and returns acks/match data.
module uart_cmd_responder #(
    parameter int MATCH_BYTES    = 19,
    parameter int TEST_COUNT     = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_cmd_responder_if.slave bus
);
    localparam int TXW = 8 * (MATCH_BYTES + 2);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, HASH_RX, LEN_HI, LEN_LO, TEXT_RX, TEXT_WAIT, TX_LOAD, TX_GAP} state_t;

    state_t         state, state_nx;
    logic [119:0]   stage, stage_nx;
    logic [127:0]   target_hash, hash_nx;
    logic [3:0]     hcnt, hcnt_nx;
    logic [15:0]    len, len_nx;
    logic [7:0]     text_byte, text_byte_nx, tx_rem, rem_nx, ack_byte;
    logic [TXW-1:0] tx_buf, buf_nx;
    logic [TW-1:0]  tmo, tmo_nx;
    logic           hash_valid, hash_valid_nx, text_valid, text_valid_nx, text_last, text_last_nx;
    logic           match_flag, flag_nx, tx_test, test_nx, tx_start, ack_en, timed, ev;

    always_comb begin
        state_nx      = state;
        stage_nx      = stage;
        hash_nx       = target_hash;
        hcnt_nx       = hcnt;
        len_nx        = len;
        text_byte_nx  = text_byte;
        rem_nx        = tx_rem;
        buf_nx        = tx_buf;
        flag_nx       = match_flag;
        test_nx       = tx_test;
        hash_valid_nx = 1'b0;
        text_valid_nx = 1'b0;
        text_last_nx  = 1'b0;
        tx_start      = 1'b0;
        ack_en        = 1'b0;
        ack_byte      = 8'h00;
        timed         = state inside {HASH_RX, LEN_HI, LEN_LO, TEXT_RX, TEXT_WAIT};
        ev            = (state == TEXT_WAIT) ? bus.proc_done : bus.rx_data_ready;
        tmo_nx        = (!timed || ev) ? '0 : tmo + 1'b1;
        case (state)
            IDLE: begin
                hcnt_nx = '0;
                if (bus.rx_data_ready) begin
                    state_nx = bus.rx_data == 8'h01 ? HASH_RX :
                               bus.rx_data == 8'h02 ? LEN_HI :
                               (bus.rx_data == 8'h03 || bus.rx_data == 8'h04) ? TX_LOAD : IDLE;
                    if (bus.rx_data == 8'h03 || bus.rx_data == 8'h04) begin
                        test_nx = bus.rx_data == 8'h04;
                        rem_nx  = bus.rx_data == 8'h04 ? 8'(TEST_COUNT) : 8'(MATCH_BYTES + 2);
                        buf_nx  = {bus.match_pos, bus.match_str};
                    end
                end
            end
            HASH_RX: if (bus.rx_data_ready) begin
                stage_nx = {stage[111:0], bus.rx_data};
                hcnt_nx  = hcnt + 1'b1;
                if (hcnt == 4'd15) begin
                    hash_nx       = {stage, bus.rx_data};
                    hash_valid_nx = 1'b1;
                    ack_en        = 1'b1;
                    ack_byte      = 8'h01;
                end
            end
            LEN_HI: if (bus.rx_data_ready) begin
                len_nx   = {bus.rx_data, 8'h00};
                state_nx = LEN_LO;
            end
            LEN_LO: if (bus.rx_data_ready) begin
                len_nx   = {len[15:8], bus.rx_data};
                ack_en   = {len[15:8], bus.rx_data} == 16'd0;
                state_nx = TEXT_RX;
            end
            TEXT_RX: if (bus.rx_data_ready) begin
                text_valid_nx = 1'b1;
                text_byte_nx  = bus.rx_data;
                text_last_nx  = len == 16'd1;
                len_nx        = len - 1'b1;
                state_nx      = len == 16'd1 ? TEXT_WAIT : TEXT_RX;
            end
            TEXT_WAIT: if (bus.proc_done) begin
                flag_nx  = bus.match;
                ack_en   = 1'b1;
                ack_byte = {7'b0, bus.match};
            end
            TX_LOAD: if (!bus.tx_busy) begin
                tx_start = 1'b1;
                buf_nx   = tx_buf << 8;
                rem_nx   = tx_rem - 1'b1;
                state_nx = TX_GAP;
            end
            TX_GAP: if (!bus.tx_busy) state_nx = tx_rem == 8'd0 ? IDLE : TX_LOAD;
        endcase
        // Single-byte acks share the transmit buffer with READ_MATCH responses
        if (ack_en) begin
            buf_nx   = {ack_byte, {(TXW-8){1'b0}}};
            test_nx  = 1'b0;
            rem_nx   = 8'd1;
            state_nx = TX_LOAD;
        end
        if (timed && !ev && tmo == TW'(TIMEOUT_CYCLES - 1)) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage       <= '0;
            target_hash <= '0;
            hcnt        <= '0;
            len         <= '0;
            text_byte   <= '0;
            tx_rem      <= '0;
            tx_buf      <= '0;
            tmo         <= '0;
            hash_valid  <= 1'b0;
            text_valid  <= 1'b0;
            text_last   <= 1'b0;
            match_flag  <= 1'b0;
            tx_test     <= 1'b0;
        end else begin
            stage       <= stage_nx;
            target_hash <= hash_nx;
            hcnt        <= hcnt_nx;
            len         <= len_nx;
            text_byte   <= text_byte_nx;
            tx_rem      <= rem_nx;
            tx_buf      <= buf_nx;
            tmo         <= tmo_nx;
            hash_valid  <= hash_valid_nx;
            text_valid  <= text_valid_nx;
            text_last   <= text_last_nx;
            match_flag  <= flag_nx;
            tx_test     <= test_nx;
        end
    end

    // TEST bytes count down from TEST_COUNT, which is exactly the remaining byte count
    assign bus.tx_data     = tx_test ? tx_rem : tx_buf[TXW-1 -: 8];
    assign bus.tx_start    = tx_start;
    assign bus.target_hash = target_hash;
    assign bus.hash_valid  = hash_valid;
    assign bus.text_valid  = text_valid;
    assign bus.text_byte   = text_byte;
    assign bus.text_last   = text_last;
    assign bus.busy        = state != IDLE;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: directed, table-driven bench for the UART command responder.
module tb_uart_cmd_responder;
    localparam int MB = 19;
    localparam int TC = 8;
    localparam int TO = 40;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_responder_if #(.MATCH_BYTES(MB)) bus();

    uart_cmd_responder #(.MATCH_BYTES(MB), .TEST_COUNT(TC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        string       name;
        logic [23:0] cmd;
        int          ncmd;
        int          exp_n;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
        int          exp_text;
        int          exp_busy;
    } vec_t;

    int         passed = 0;
    int         total = 0;
    logic [7:0] tx_q[$];
    logic [7:0] text_q[$];
    int         last_q[$];
    int         hv_cnt = 0;
    int         viol = 0;
    int         busy_cyc = 0;
    logic [2:0] bcnt;

    // Transmitter model: busy for five cycles after each start
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)          bcnt <= 3'd0;
        else if (bus.tx_start) bcnt <= 3'd5;
        else if (bcnt != 3'd0) bcnt <= bcnt - 3'd1;
    end
    assign bus.tx_busy = bcnt != 3'd0;

    always @(negedge clk) begin
        if (bus.tx_start) tx_q.push_back(bus.tx_data);
        if (bus.tx_start && bus.tx_busy) viol++;
        if (bus.text_valid) begin
            if (bus.text_last) last_q.push_back(text_q.size());
            text_q.push_back(bus.text_byte);
        end
        if (bus.hash_valid) hv_cnt++;
        if (bus.busy) busy_cyc++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic send(logic [7:0] b);
        bus.rx_data       = b;
        bus.rx_data_ready = 1'b1;
        tick();
        bus.rx_data_ready = 1'b0;
    endtask

    task automatic pulse_done(logic m);
        bus.match     = m;
        bus.proc_done = 1'b1;
        tick();
        bus.proc_done = 1'b0;
    endtask

    task automatic wait_idle(string nm);
        int i = 0;
        while (bus.busy && i < 2000) begin
            tick();
            i++;
        end
        chk(nm, 128'(bus.busy), 128'(0));
    endtask

    task automatic set_hash(logic [127:0] h);
        send(8'h01);
        for (int k = 0; k < 16; k++) send(h[127-8*k -: 8]);
    endtask

    task automatic check_reset_outputs(string nm);
        chk({nm, "_busy"}, 128'(bus.busy), 128'(0));
        chk({nm, "_tx_start"}, 128'(bus.tx_start), 128'(0));
        chk({nm, "_tx_data"}, 128'(bus.tx_data), 128'(0));
        chk({nm, "_hash"}, bus.target_hash, 128'(0));
        chk({nm, "_hash_valid"}, 128'(bus.hash_valid), 128'(0));
        chk({nm, "_text"}, {119'(0), bus.text_valid, bus.text_byte}, 128'(0));
        chk({nm, "_text_last"}, 128'(bus.text_last), 128'(0));
    endtask

    vec_t        vt[5];
    logic [127:0] h1, h2, h3, hsave;
    logic [8*MB-1:0] ms;
    int tb0, xb0, lb0, hb0, bb0, err, n;

    initial begin
        vt[0] = '{"test_cmd", 24'h040000, 1, TC, 8'(TC), 8'h01, 0, 1};
        vt[1] = '{"unk_7f",   24'h7f0000, 1, 0,  8'h00, 8'h00, 0, 0};
        vt[2] = '{"unk_00",   24'h000000, 1, 0,  8'h00, 8'h00, 0, 0};
        vt[3] = '{"zero_len", 24'h020000, 3, 1,  8'h00, 8'h00, 0, 1};
        vt[4] = '{"unk_ff",   24'hff0000, 1, 0,  8'h00, 8'h00, 0, 0};
        h1 = 128'h7e2ba776cc7b346f3592bfedb41b18bd;
        h2 = 128'h00112233445566778899aabbccddeeff;
        h3 = 128'hdeadbeef0123456789abcdefcafef00d;

        bus.rx_data_ready = 1'b0;
        bus.rx_data       = 8'h00;
        bus.proc_done     = 1'b0;
        bus.match         = 1'b0;
        bus.match_pos     = 16'h0000;
        bus.match_str     = '0;
        repeat (3) tick();
        check_reset_outputs("rst_hold");
        reset_n = 1'b1;
        repeat (2) tick();
        check_reset_outputs("rst_rel");

        // SET_HASH: no partial hash, pulse the cycle after the 16th byte, ack 0x01
        tb0 = tx_q.size(); hb0 = hv_cnt;
        send(8'h01);
        for (int k = 0; k < 15; k++) send(h1[127-8*k -: 8]);
        chk("hash_no_partial", bus.target_hash, 128'(0));
        send(h1[7:0]);
        chk("hash_valid_pulse", 128'(bus.hash_valid), 128'(1));
        chk("hash_value", bus.target_hash, h1);
        wait_idle("hash_idle");
        chk("hash_valid_cnt", 128'(hv_cnt - hb0), 128'(1));
        chk("hash_ack_n", 128'(tx_q.size() - tb0), 128'(1));
        chk("hash_ack", 128'(tx_q[tb0]), 128'(8'h01));

        for (int v = 0; v < 5; v++) begin
            tb0 = tx_q.size(); xb0 = text_q.size(); bb0 = busy_cyc;
            for (int k = 0; k < vt[v].ncmd; k++) send(vt[v].cmd[23-8*k -: 8]);
            wait_idle({vt[v].name, "_idle"});
            repeat (3) tick();
            chk({vt[v].name, "_tx_n"}, 128'(tx_q.size() - tb0), 128'(vt[v].exp_n));
            if (vt[v].exp_n > 0) begin
                chk({vt[v].name, "_first"}, 128'(tx_q[tb0]), 128'(vt[v].exp_first));
                chk({vt[v].name, "_last"}, 128'(tx_q[tx_q.size()-1]), 128'(vt[v].exp_last));
            end
            chk({vt[v].name, "_text_n"}, 128'(text_q.size() - xb0), 128'(vt[v].exp_text));
            chk({vt[v].name, "_busy"}, 128'(busy_cyc > bb0), 128'(vt[v].exp_busy));
        end

        // TEST: full countdown content
        tb0 = tx_q.size();
        send(8'h04);
        wait_idle("test_idle");
        err = 0;
        for (int k = 0; k < TC; k++) if (tx_q[tb0+k] !== 8'(TC - k)) err++;
        chk("test_seq", 128'(err), 128'(0));

        // SEND_TEXT 200 bytes, no match
        tb0 = tx_q.size(); xb0 = text_q.size(); lb0 = last_q.size();
        send(8'h02); send(8'h00); send(8'hC8);
        for (int k = 0; k < 200; k++) send(8'(k * 37 + 5));
        repeat (2) tick();
        chk("text_n", 128'(text_q.size() - xb0), 128'(200));
        err = 0;
        for (int k = 0; k < 200; k++) if (text_q[xb0+k] !== 8'(k * 37 + 5)) err++;
        chk("text_order", 128'(err), 128'(0));
        chk("text_last_n", 128'(last_q.size() - lb0), 128'(1));
        chk("text_last_idx", 128'(last_q[lb0]), 128'(xb0 + 199));
        chk("text_wait_busy", 128'(bus.busy), 128'(1));
        send(8'h04);
        repeat (10) tick();
        chk("text_wait_rx_ignored", 128'(tx_q.size() - tb0), 128'(0));
        pulse_done(1'b0);
        wait_idle("nomatch_idle");
        chk("nomatch_ack_n", 128'(tx_q.size() - tb0), 128'(1));
        chk("nomatch_ack", 128'(tx_q[tb0]), 128'(8'h00));

        // Match path then READ_MATCH, inputs changed right after the opcode
        tb0 = tx_q.size(); xb0 = text_q.size();
        send(8'h02); send(8'h00); send(8'h03);
        send(8'h61); send(8'h62); send(8'h63);
        repeat (2) tick();
        chk("match_text_n", 128'(text_q.size() - xb0), 128'(3));
        pulse_done(1'b1);
        wait_idle("match_idle");
        chk("match_ack", 128'(tx_q[tb0]), 128'(8'h01));
        for (int k = 0; k < MB; k++) ms[8*(MB-1-k) +: 8] = 8'(8'hA0 + k);
        bus.match_pos = 16'h0076;
        bus.match_str = ms;
        tb0 = tx_q.size();
        send(8'h03);
        bus.match_pos = 16'hFFFF;
        bus.match_str = '0;
        wait_idle("read_idle");
        chk("read_n", 128'(tx_q.size() - tb0), 128'(MB + 2));
        err = 0;
        for (int k = 0; k < MB + 2; k++)
            if (tx_q[tb0+k] !== (k == 0 ? 8'h00 : k == 1 ? 8'h76 : 8'(8'hA0 + k - 2))) err++;
        chk("read_bytes", 128'(err), 128'(0));
        chk("tx_busy_respected", 128'(viol), 128'(0));

        // Timeout abort mid SET_HASH, then a full SET_HASH succeeds
        hsave = bus.target_hash; tb0 = tx_q.size(); hb0 = hv_cnt;
        send(8'h01);
        for (int k = 0; k < 5; k++) send(8'h55);
        repeat (TO + 1) tick();
        chk("tmo_busy", 128'(bus.busy), 128'(0));
        chk("tmo_hash", bus.target_hash, hsave);
        chk("tmo_no_ack", 128'(tx_q.size() - tb0), 128'(0));
        chk("tmo_no_hv", 128'(hv_cnt - hb0), 128'(0));
        set_hash(h2);
        wait_idle("tmo_after_idle");
        chk("tmo_after_hash", bus.target_hash, h2);
        chk("tmo_after_ack", 128'(tx_q.size() - tb0), 128'(1));

        // Each byte lands in the expiry cycle and must still be accepted
        tb0 = tx_q.size();
        send(8'h01);
        for (int k = 0; k < 16; k++) begin
            repeat (TO - 1) tick();
            send(h3[127-8*k -: 8]);
        end
        wait_idle("edge_idle");
        chk("edge_hash", bus.target_hash, h3);
        chk("edge_ack", 128'(tx_q.size() - tb0), 128'(1));

        // Reset in the middle of a READ_MATCH response
        tb0 = tx_q.size();
        send(8'h03);
        for (int i = 0; i < 500 && tx_q.size() - tb0 < 3; i++) tick();
        chk("rm_progress", 128'(tx_q.size() - tb0 >= 3), 128'(1));
        n = tx_q.size();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (60) tick();
        chk("rst_no_tx", 128'(tx_q.size()), 128'(n));
        chk("rst_idle", 128'(bus.busy), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
